// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, runs a single-outstanding request/ack handshake
// to instruction memory and presents each fetched word with its next-PC to IF/ID.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] npc_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] inst_q;
  logic [31:0] npc_q;
  logic [31:0] drain_addr;
  logic        load_inst;
  logic        load_drain;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = {redirect_pc[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= REQ;
      pc         <= RESET_PC;
      inst_q     <= 32'd0;
      npc_q      <= 32'd0;
      drain_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (load_inst) begin
        inst_q <= imem_rdata;
        npc_q  <= pc_plus4;
      end
      if (load_drain) begin
        drain_addr <= pc;
      end
    end
  end

  // A redirect while a request is pending must still wait for that ack,
  // so the old address is parked in drain_addr while pc takes the target.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    load_inst  = 1'b0;
    load_drain = 1'b0;
    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_next = target;
          if (!imem_ack) begin
            state_next = DRAIN;
            load_drain = 1'b1;
          end
        end else if (imem_ack) begin
          load_inst  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = target;
          state_next = REQ;
        end else if (!hazard_in) begin
          pc_next    = pc_plus4;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_next = target;
        end
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  // Outputs are gated by rst_n so they drop the moment reset is asserted.
  always_comb begin
    imem_req  = (state != HOLD) && rst_n;
    imem_addr = (state == DRAIN) ? drain_addr : pc;
    instr_out = (state == HOLD) ? inst_q : 32'd0;
    npc_out   = (state == HOLD) ? npc_q : 32'd0;
    flush_out = redirect_valid & rst_n;
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: two instances (normal and wrap-around reset PC)
// share stimulus; memory returns address ^ KEY with a bench-controlled ack.
module tb_fetch_pc_unit;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_n;
  logic        hazard_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ack;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] npc_out;
  logic        flush_out;

  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] instr_out_w;
  logic [31:0] npc_out_w;
  logic        flush_out_w;

  int tests_run;
  int tests_failed;

  assign imem_rdata   = imem_addr ^ KEY;
  assign imem_rdata_w = imem_addr_w ^ KEY;

  fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_in      (hazard_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_out      (instr_out),
    .npc_out        (npc_out),
    .flush_out      (flush_out)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .hazard_in      (hazard_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req_w),
    .imem_addr      (imem_addr_w),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata_w),
    .instr_out      (instr_out_w),
    .npc_out        (npc_out_w),
    .flush_out      (flush_out_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic hz, input logic rv,
                               input logic [31:0] rpc, input logic ack);
    @(negedge clk);
    rst_n          = rst;
    hazard_in      = hz;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    #1;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  // Address is only meaningful while requesting or held in reset.
  task automatic checkOutput(input string tag, input bit wrap, input logic exp_req,
                             input logic [31:0] exp_addr, input logic [31:0] exp_instr,
                             input logic [31:0] exp_npc, input logic exp_flush);
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        fl;
    req   = wrap ? imem_req_w  : imem_req;
    addr  = wrap ? imem_addr_w : imem_addr;
    instr = wrap ? instr_out_w : instr_out;
    npc   = wrap ? npc_out_w   : npc_out;
    fl    = wrap ? flush_out_w : flush_out;
    checkField(tag, "req", {31'd0, req}, {31'd0, exp_req});
    if (exp_req || !rst_n) checkField(tag, "addr", addr, exp_addr);
    checkField(tag, "instr", instr, exp_instr);
    checkField(tag, "npc", npc, exp_npc);
    checkField(tag, "flush", {31'd0, fl}, {31'd0, exp_flush});
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst_n          = 1'b0;
    hazard_in      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    imem_ack       = 1'b0;

    applyStimulus(0, 0, 1, 32'h2003, 0);
    checkOutput("reset", 0, 0, 32'h100, 0, 0, 0);
    checkOutput("reset_w", 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_ack", 0, 0, 32'h100, 0, 0, 0);

    // Sequential zero-wait fetch
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("seq0_req", 0, 1, 32'h100, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("seq0_hold", 0, 0, 0, 32'h100 ^ KEY, 32'h104, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("seq1_req", 0, 1, 32'h104, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("seq1_hold", 0, 0, 0, 32'h104 ^ KEY, 32'h108, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("seq2_req", 0, 1, 32'h108, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("seq2_hold", 0, 0, 0, 32'h108 ^ KEY, 32'h10C, 0);

    // Latency 3 then latency 7
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("lat3_wait", 0, 1, 32'h10C, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("lat3_ack", 0, 1, 32'h10C, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lat3_hold", 0, 0, 0, 32'h10C ^ KEY, 32'h110, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("lat7_wait", 0, 1, 32'h110, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("lat7_ack", 0, 1, 32'h110, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lat7_hold", 0, 0, 0, 32'h110 ^ KEY, 32'h114, 0);

    // Stall in HOLD for 4 cycles
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("stall_req", 0, 1, 32'h114, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("stall_hold", 0, 0, 0, 32'h114 ^ KEY, 32'h118, 0);
    end
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stall_release", 0, 0, 0, 32'h114 ^ KEY, 32'h118, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("stall_next", 0, 1, 32'h118, 0, 0, 0);

    // Redirect in REQ without ack: drain the stale request first
    applyStimulus(1, 0, 1, 32'h2003, 0);
    checkOutput("rdq_pulse", 0, 1, 32'h118, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rdq_drain", 0, 1, 32'h118, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rdq_drain_ack", 0, 1, 32'h118, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rdq_target", 0, 1, 32'h2000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rdq_hold", 0, 0, 0, 32'h2000 ^ KEY, 32'h2004, 0);

    // Redirect in REQ coincident with ack
    applyStimulus(1, 0, 1, 32'h2003, 1);
    checkOutput("rda_pulse", 0, 1, 32'h2004, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rda_target", 0, 1, 32'h2000, 0, 0, 0);

    // Redirect in HOLD under stall
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("rdh_hold", 0, 0, 0, 32'h2000 ^ KEY, 32'h2004, 0);
    applyStimulus(1, 1, 1, 32'h2003, 0);
    checkOutput("rdh_pulse", 0, 0, 0, 32'h2000 ^ KEY, 32'h2004, 1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("rdh_target", 0, 1, 32'h2000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rdh_hold2", 0, 0, 0, 32'h2000 ^ KEY, 32'h2004, 0);

    // Two redirects during DRAIN: second target wins
    applyStimulus(1, 0, 1, 32'h5001, 0);
    checkOutput("rdd_first", 0, 1, 32'h2004, 0, 0, 1);
    applyStimulus(1, 0, 1, 32'h2003, 0);
    checkOutput("rdd_second", 0, 1, 32'h2004, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rdd_ack", 0, 1, 32'h2004, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("rdd_target", 0, 1, 32'h2000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rdd_hold", 0, 0, 0, 32'h2000 ^ KEY, 32'h2004, 0);

    // Reset mid-request, then wrap-around on the second instance
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("mid_wait", 0, 1, 32'h2004, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("mid_reset", 0, 0, 32'h100, 0, 0, 0);
    checkOutput("mid_reset_w", 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart", 0, 1, 32'h100, 0, 0, 0);
    checkOutput("restart_w", 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("restart_ack", 0, 1, 32'h100, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart_hold", 0, 0, 0, 32'h100 ^ KEY, 32'h104, 0);
    checkOutput("wrap_hold", 1, 0, 0, 32'hFFFF_FFFC ^ KEY, 32'h0000_0000, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart_next", 0, 1, 32'h104, 0, 0, 0);
    checkOutput("wrap_next", 1, 1, 32'h0000_0000, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and instruction-memory front end that feeds the stage-1 IF/ID pipeline register. It generates fetch addresses, runs the request/acknowledge handshake to instruction memory, and presents each fetched instruction with its next-PC. It honours stall (`hazard_in`) and branch/jump redirects, and drives the register's flush input. Whenever no valid instruction is ready, it outputs a bubble (all-zero instruction and NPC), which the IF/ID register latches as a NOP.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `hazard_in` in 1: stall from hazard unit; same signal drives the IF/ID register.
- `redirect_valid` in 1: one-cycle pulse; branch/jump taken.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored and forced to 0.
- `imem_req` out 1: instruction-memory request.
- `imem_addr` out 32: request address, word aligned.
- `imem_ack` in 1: one-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `instr_out` out 32: instruction to IF/ID; 0 when no instruction is ready.
- `npc_out` out 32: PC+4 of `instr_out`; 0 when no instruction is ready.
- `flush_out` out 1: flush to IF/ID; equals `redirect_valid & rst_n`, combinational.

## Operation
- **State registers:** `pc` (32 bits), `inst_q` (32 bits), `npc_q` (32 bits), and a 2-bit FSM with states REQ, HOLD and DRAIN.
- **Memory protocol:**
  - Once `imem_req` rises, it stays high with `imem_addr` stable until the cycle in which `imem_ack` = 1.
  - Only one request is outstanding at a time.
  - A request is never abandoned before its ack.
- **REQ:**
  - `imem_req` = 1, `imem_addr` = `pc`, outputs show a bubble.
  - On ack with no redirect: `inst_q` <= `imem_rdata`, `npc_q` <= `pc` + 4, go to HOLD.
  - Redirect with no ack: `pc` <= `redirect_pc`, go to DRAIN.
  - Redirect coincident with ack: discard the data, `pc` <= `redirect_pc`, stay in REQ.
- **HOLD:**
  - `imem_req` = 0, `instr_out` = `inst_q`, `npc_out` = `npc_q`.
  - `hazard_in` = 0: the instruction is consumed at this edge; `pc` <= `pc` + 4, go to REQ.
  - `hazard_in` = 1: stay in HOLD; outputs are unchanged.
  - Redirect (takes priority over `hazard_in`): discard the instruction, `pc` <= `redirect_pc`, go to REQ.
- **DRAIN:**
  - `imem_req` = 1 with the stale address held in a separate `drain_addr` register; outputs show a bubble.
  - On ack: discard the data, go to REQ; `pc` already holds the target.
  - A further redirect while in DRAIN overwrites `pc` (latest target wins).
- **Arithmetic:** PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000. `npc_out` follows the same rule.
- **Reset (asserted at any time, including mid-request):**
  - Immediately: `pc` = `RESET_PC`, FSM = REQ, `imem_req` = 0, `instr_out` = 0, `npc_out` = 0, `flush_out` = 0, `imem_addr` = `RESET_PC`.
  - Instruction memory shares `rst_n`, so any outstanding request is also cleared in memory.
- `imem_req` rises in the first cycle after `rst_n` deasserts.

## Timing
- **Fetch latency:** request issued in cycle T; ack in cycle T+L (L ≥ 0 extra wait cycles); instruction visible on `instr_out` from cycle T+L+1.
- **IF/ID capture:** the instruction is captured into IF/ID at the end of the first HOLD cycle in which `hazard_in` = 0.
- **Throughput:** one instruction per L+2 cycles when unstalled. Overlapped fetch is out of scope.
- **Redirect:**
  - `flush_out` is high in the redirect cycle only.
  - The first request to the target is issued in the next cycle (from REQ or HOLD), or in the cycle after the drain ack (from DRAIN).
- **Stall:** `hazard_in` held for N cycles holds `instr_out` and `npc_out` constant for N cycles; `pc` does not advance.

## Test plan
- **Reset and sequential fetch:** `RESET_PC` = 0x100, zero-wait memory returning `imem_addr`^0xA5A5A5A5.
  - `imem_addr` sequence is 0x100, 0x104, 0x108.
  - Each `instr_out` is matched with `npc_out` = 0x104, 0x108, 0x10C.
  - A bubble appears between instructions.
- **Variable latency:** ack delayed 0, 3 and 7 cycles.
  - `imem_addr` stays stable until ack.
  - Outputs show bubbles until the cycle after ack.
  - No instruction is lost or duplicated.
- **Stall in HOLD:** `hazard_in` = 1 for 4 cycles.
  - `instr_out`/`npc_out` stay constant and `imem_req` stays 0.
  - After release, the next `imem_addr` = previous PC + 4.
- **Redirect in each state:** `redirect_pc` = 0x2003 during REQ (no ack), REQ with ack, HOLD under stall, and DRAIN.
  - `flush_out` pulses once.
  - The stale data is never output.
  - The next new request uses `imem_addr` = 0x2000.
  - In DRAIN, two redirects produce the second target.
- **Wrap and reset mid-request:**
  - Wrap: `RESET_PC` = 0xFFFFFFFC gives `npc_out` = 0 and a next `imem_addr` of 0.
  - Reset mid-request: asserting `rst_n` = 0 during a wait drops `imem_req` immediately, and fetch restarts at `RESET_PC`.
